dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the word-addressed data memory (1024 x 32, combinational read, write on clock edge).
- Port 0 is the CPU MEM stage and port 1 is the debug/DMA loader; they share the single memory port under round-robin arbitration.
- Each access is a 3-state req/ack transaction.
- Aligned, in-range byte addresses are checked before the memory is touched.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  // Default memory depth in 32-bit words, and byte-address width
  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_AW    = 32;

  // Requester port indices
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module      : rr_arb2
// Description : Two-way round-robin pick. When both ports request, the port
//               that did not win last time is chosen.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic gnt_valid,
  output logic gnt_idx
);

  // Grant a lone requester directly; break ties against the last winner
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT_CPU;
    if (req0 && req1) begin
      gnt_idx = ~rr_last;
    end else if (req1) begin
      gnt_idx = PORT_DBG;
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter and 3-state req/ack sequencer in
//               front of a word-addressed data memory. Addresses are checked
//               for alignment and range before the memory is written.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // Port 0: CPU MEM stage
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [31:0]   wdata0_i,
  output logic          ack0_o,
  output logic          err0_o,
  output logic [31:0]   rdata0_o,
  // Port 1: debug / DMA loader
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [31:0]   wdata1_i,
  output logic          ack1_o,
  output logic          err1_o,
  output logic [31:0]   rdata1_o,
  // Data memory
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  // One past the last legal byte address
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(4 * DEPTH);

  state_e        state_q,  state_d;
  logic          gnt_q,    gnt_d;
  logic          rr_last_q, rr_last_d;
  logic          we_q,     we_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic          ack0_q,   ack0_d;
  logic          ack1_q,   ack1_d;
  logic          err0_q,   err0_d;
  logic          err1_q,   err1_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  logic          arb_valid;
  logic          arb_idx;
  logic          legal;
  logic [31:0]   rd_capture;

  rr_arb2 u_rr_arb2 (
    .req0      (req0_i),
    .req1      (req1_i),
    .rr_last   (rr_last_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Legality of the latched address, and the data a read would return
  always_comb begin
    legal      = (addr_q[1:0] == 2'b00) && (addr_q < ADDR_LIMIT);
    rd_capture = legal ? mem_rdata_i : 32'h0;
  end

  // Next-state, request latching and response capture
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d     = arb_idx;
          rr_last_d = arb_idx;
          we_d      = (arb_idx == PORT_DBG) ? we1_i    : we0_i;
          addr_d    = (arb_idx == PORT_DBG) ? addr1_i  : addr0_i;
          wdata_d   = (arb_idx == PORT_DBG) ? wdata1_i : wdata0_i;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Writes leave the port's read data untouched
        if (gnt_q == PORT_DBG) begin
          ack1_d = 1'b1;
          err1_d = ~legal;
          if (!we_q) rdata1_d = rd_capture;
        end else begin
          ack0_d = 1'b1;
          err0_d = ~legal;
          if (!we_q) rdata0_d = rd_capture;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= PORT_CPU;
      rr_last_q <= PORT_DBG;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Write strobe is gated by state so it falls as soon as reset hits
  assign mem_we_o    = (state_q == ACCESS) && we_q && legal;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign ack0_o   = ack0_q;
  assign err0_o   = err0_q;
  assign rdata0_o = rdata0_q;
  assign ack1_o   = ack1_q;
  assign err1_o   = err1_q;
  assign rdata1_o = rdata1_q;

endmodule : dmem_arbiter

`default_nettype wire
